// File: rtl/astrio_fetch_queue.sv
// astrio_fetch_queue: sequential imem fetch with an in-order in-flight tracker feeding a DEPTH-entry {inst, pc} FIFO toward ID.
// Latency: a response is written at its edge and is visible on out_* from the FIFO head register; redirects flush and kill in-flight work.
// Backpressure: out_ready stalls the head; requests stop when FIFO occupancy plus in-flight would exceed DEPTH. Optional ASTRIO_FQ_STATS_EN adds counters.
module astrio_fetch_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH = 4,
    parameter int MAX_OUT = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         mem_req_valid,
    output logic [ADDR_W-1:0]            mem_req_addr,
    input  logic                         mem_req_ready,
    input  logic                         mem_resp_valid,
    input  logic [INST_W-1:0]            mem_resp_inst,
    output logic                         out_valid,
    output logic [INST_W-1:0]            out_inst,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [ADDR_W-1:0]            out_inc_pc,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [31:0]                  stat_redirects,
    output logic [31:0]                  stat_dropped
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [INST_W-1:0] fifo_inst [DEPTH];
    logic [ADDR_W-1:0] fifo_pc [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count_q;
    logic [ADDR_W-1:0] trk_pc [MAX_OUT];
    logic [MAX_OUT-1:0] trk_killed;
    logic [TW-1:0]     trk_head, trk_tail;
    logic [OW-1:0]     outstanding;
    logic [31:0]       inflight;
    logic              req_fire, resp_take, resp_keep, pop;
    logic [1:0]        unused_redirect_lsb;

    function automatic logic [TW-1:0] trk_next(input logic [TW-1:0] i);
        return (i == TW'(MAX_OUT - 1)) ? '0 : i + TW'(1);
    endfunction

    assign unused_redirect_lsb = redirect_pc[1:0];
    assign inflight = 32'(count_q) + 32'(outstanding);

    // Gated by rst so no request is presented while the block is held in reset.
    assign mem_req_valid = rst && !redirect_valid && (inflight < 32'(DEPTH))
                           && (32'(outstanding) < 32'(MAX_OUT));
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign resp_take     = mem_resp_valid && (outstanding != '0);
    assign resp_keep     = resp_take && !redirect_valid && !trk_killed[trk_head];
    assign out_valid     = (count_q != '0);
    assign pop           = out_valid && out_ready && !redirect_valid;
    assign out_inst      = fifo_inst[rd_ptr];
    assign out_pc        = fifo_pc[rd_ptr];
    assign out_inc_pc    = out_pc + ADDR_W'(4);
    assign count         = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            trk_head    <= '0;
            trk_tail    <= '0;
            outstanding <= '0;
            trk_killed  <= '0;
        end else begin
            if (resp_take)
                trk_head <= trk_next(trk_head);
            if (req_fire) begin
                trk_tail <= trk_next(trk_tail);
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_take);
            if (redirect_valid) begin
                // No request can fire in a redirect cycle, so killing every slot is safe.
                fetch_pc   <= {redirect_pc[ADDR_W-1:2], 2'b00};
                trk_killed <= '1;
                wr_ptr     <= rd_ptr;
                count_q    <= '0;
            end else begin
                if (req_fire)
                    trk_killed[trk_tail] <= 1'b0;
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (resp_keep)
                    wr_ptr <= wr_ptr + PW'(1);
                count_q <= count_q + CW'(resp_keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (resp_keep) begin
            fifo_inst[wr_ptr] <= mem_resp_inst;
            fifo_pc[wr_ptr]   <= trk_pc[trk_head];
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            trk_pc[trk_tail] <= fetch_pc;
    end

`ifdef ASTRIO_FQ_STATS_EN
    logic        resp_drop;
    logic [31:0] redirects_q, dropped_q;

    assign resp_drop = resp_take && !resp_keep;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirects_q <= '0;
            dropped_q   <= '0;
        end else begin
            if (redirect_valid && (redirects_q != '1))
                redirects_q <= redirects_q + 32'd1;
            if (resp_drop && (dropped_q != '1))
                dropped_q <= dropped_q + 32'd1;
        end
    end

    assign stat_redirects = redirects_q;
    assign stat_dropped   = dropped_q;
`else
    assign stat_redirects = '0;
    assign stat_dropped   = '0;
`endif

endmodule
